wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the register-file write port at the write-back stage.
//  Picks the pipeline write-back source: ALU result, memory load data, or link address (PC+8).
//  Arbitrates that port against register writes from the debug unit.
//  Pipeline has priority; a starvation counter bounds debug wait by stalling write-back for one cycle.
//  Write-port outputs are registered; sits between MEM/WB register and register file.
// PARAMETERS
//  NB_DATA   32  data width of register-file write port
//  NB_ADDR   5   register address width
//  NB_SEL    2   write-back source select width
//  MAX_WAIT  4   deferred cycles before forced stall; legal range >=1
// PORTS
//  clock_i      in   1        system clock, rising edge
//  reset_n_i    in   1        asynchronous, active-low reset
//  pipe_we_i    in   1        pipeline write-back enable
//  pipe_addr_i  in   NB_ADDR  pipeline destination register
//  pipe_sel_i   in   NB_SEL   source select: 00 ALU, 01 MEM, 10 LINK, 11 ALU
//  alu_data_i   in   NB_DATA  ALU result
//  mem_data_i   in   NB_DATA  load data
//  link_data_i  in   NB_DATA  return address (PC+8)
//  dbg_req_i    in   1        debug write request, level, 4-phase
//  dbg_addr_i   in   NB_ADDR  debug destination register
//  dbg_data_i   in   NB_DATA  debug write data
//  dbg_ack_o    out  1        one-cycle pulse: debug write performed
//  stall_o      out  1        hold write-back stage; pipeline re-presents its write
//  rf_we_o      out  1        register-file write enable (registered)
//  rf_addr_o    out  NB_ADDR  register-file write address (registered)
//  rf_data_o    out  NB_DATA  register-file write data (registered)
// BEHAVIOUR
//  - Reset (async, reset_n_i=0):
//    - state=S_IDLE, wait_cnt=0.
//    - rf_we_o, rf_addr_o, rf_data_o, dbg_ack_o and stall_o all 0.
//    - In-flight grant is dropped; no ack is issued.
//  - Latency: cycle-n decision appears on rf_*_o and dbg_ack_o after edge n+1. stall_o = (state==S_STALL), Moore.
//  - pw (effective pipe write) = pipe_we_i && pipe_addr_i!=0. Writes to $0 never reach rf_we_o.
//  - Pipe pass: rf_we_o<=pw, rf_addr_o<=pipe_addr_i, rf_data_o<=mux(pipe_sel_i).
//  - Debug grant:
//    - rf_we_o<=(dbg_addr_i!=0), rf_addr_o<=dbg_addr_i, rf_data_o<=dbg_data_i.
//    - dbg_ack_o<=1, wait_cnt<=0, next state S_ACK.
//    - Writes to $0 are dropped but still acked.
//  - dbg_ack_o defaults to 0; it is high for exactly one cycle per grant.
//  - S_IDLE/S_WAIT, dbg_req_i=0: pipe pass; wait_cnt<=0; next S_IDLE.
//  - S_IDLE/S_WAIT, dbg_req_i=1, pw=0: debug grant.
//  - S_IDLE/S_WAIT, dbg_req_i=1, pw=1: pipe pass.
//    - If wait_cnt==MAX_WAIT-1: next S_STALL.
//    - Otherwise: wait_cnt++, next S_WAIT.
//  - S_STALL: stall_o=1; pipe inputs are ignored; debug grant.
//  - S_ACK: pipe pass; no grant. Leave for S_IDLE only once dbg_req_i=0, so a held request is never re-granted.
//  - Withdrawn request (req drops in S_WAIT): back to S_IDLE, wait_cnt cleared, no ack.
//  - Simultaneous pw and grant from S_IDLE/S_WAIT never happen; the pipeline always wins there.
//  - Worst case: debug writes MAX_WAIT+1 cycles after req.
//  - wait_cnt width: $clog2(MAX_WAIT+1); it never exceeds MAX_WAIT-1.
// TESTING
//  - Reset, then pipe_we=1, addr=5, sel=01, mem=0xDEADBEEF.
//    -> next cycle rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF.
//  - sel=10, link=0x00400008, addr=31 -> rf_data_o=0x00400008.
//    sel=11, alu=0x11 -> rf_data_o=0x11.
//    pipe_we=1 with addr=0 -> rf_we_o=0.
//  - Pipe idle; dbg_req=1, addr=7, data=0x1234, req held 4 cycles.
//    -> one cycle later: rf write 7/0x1234 and a single dbg_ack_o pulse.
//    -> no second write or ack until req drops and rises again.
//  - MAX_WAIT=4; pipe writes every cycle; dbg_req rises in cycle 0.
//    -> cycles 0-3 pipe writes pass.
//    -> stall_o=1 in cycle 4 only; debug write and ack after edge 5.
//    -> the pipe write presented in cycle 4 is not written.
//  - Reset pulled low while in S_STALL.
//    -> stall_o, rf_we_o, dbg_ack_o drop at once, no ack.
//    -> after release, with req high and pipe idle: grant one cycle later.
//  - Request withdrawn after 2 deferred cycles.
//    -> no ack, stall_o stays 0, wait_cnt back to 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between write-back and debug
// Pipeline wins the port; a bounded deferral count forces a one-cycle stall so debug gets in.
module wb_port_arbiter #(
   parameter int NB_DATA  = 32,
   parameter int NB_ADDR  = 5,
   parameter int NB_SEL   = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic               pipe_we_i,
   input  logic [NB_ADDR-1:0] pipe_addr_i,
   input  logic [NB_SEL-1:0]  pipe_sel_i,
   input  logic [NB_DATA-1:0] alu_data_i,
   input  logic [NB_DATA-1:0] mem_data_i,
   input  logic [NB_DATA-1:0] link_data_i,
   input  logic               dbg_req_i,
   input  logic [NB_ADDR-1:0] dbg_addr_i,
   input  logic [NB_DATA-1:0] dbg_data_i,
   output logic               dbg_ack_o,
   output logic               stall_o,
   output logic               rf_we_o,
   output logic [NB_ADDR-1:0] rf_addr_o,
   output logic [NB_DATA-1:0] rf_data_o
);

   localparam int                NB_CNT   = $clog2(MAX_WAIT + 1);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(MAX_WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL, S_ACK} state_t;

   state_t               state, state_nxt;
   logic [NB_CNT-1:0]    wait_cnt, wait_cnt_nxt;
   logic                 we_nxt, ack_nxt, pw;
   logic [NB_ADDR-1:0]   addr_nxt;
   logic [NB_DATA-1:0]   data_nxt, pipe_data;

   assign pw      = pipe_we_i && (pipe_addr_i != '0);
   assign stall_o = (state == S_STALL);

   always_comb begin
      case (pipe_sel_i)
         NB_SEL'(1): pipe_data = mem_data_i;
         NB_SEL'(2): pipe_data = link_data_i;
         default:    pipe_data = alu_data_i;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      we_nxt       = pw;
      addr_nxt     = pipe_addr_i;
      data_nxt     = pipe_data;
      ack_nxt      = 1'b0;
      case (state)
         S_IDLE, S_WAIT: begin
            if (!dbg_req_i) begin
               wait_cnt_nxt = '0;
               state_nxt    = S_IDLE;
            end else if (!pw) begin
               we_nxt       = (dbg_addr_i != '0);
               addr_nxt     = dbg_addr_i;
               data_nxt     = dbg_data_i;
               ack_nxt      = 1'b1;
               wait_cnt_nxt = '0;
               state_nxt    = S_ACK;
            end else if (wait_cnt == CNT_LAST) begin
               state_nxt = S_STALL;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
               state_nxt    = S_WAIT;
            end
         end
         S_STALL: begin
            // The pipeline re-presents its write next cycle, so dropping it here is safe.
            we_nxt       = (dbg_addr_i != '0);
            addr_nxt     = dbg_addr_i;
            data_nxt     = dbg_data_i;
            ack_nxt      = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = S_ACK;
         end
         default: begin
            wait_cnt_nxt = '0;
            state_nxt    = dbg_req_i ? S_ACK : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         rf_we_o   <= 1'b0;
         rf_addr_o <= '0;
         rf_data_o <= '0;
         dbg_ack_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         rf_we_o   <= we_nxt;
         rf_addr_o <= addr_nxt;
         rf_data_o <= data_nxt;
         dbg_ack_o <= ack_nxt;
      end
   end

endmodule
